// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state type and op-class helper for the multiply/divide unit.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   function automatic logic is_mdu_calc(input logic [2:0] op);
      logic res;
      res = 1'b0;
      case (op)
         MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
         default:                                res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter modelling MDU latency; last_o flags the final busy cycle.
module mdu_latency_counter #(
   parameter int unsigned CntW = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            dec_i,
   output logic [CntW-1:0] cnt_o,
   output logic            last_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: latches results, models latency, commits HI/LO, requests stalls.
// Build option MDU_DIV0_HOLD_EN: divide-by-zero takes one cycle and leaves HI/LO unchanged.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_E,
   input  logic [2:0]  op_E,
   input  logic [31:0] rs_val_E,
   input  logic [31:0] rt_val_E,
   input  logic        md_D,
   output logic        busy_o,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

   mdu_state_e      state_q, state_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;
   logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic            done_q, done_d;
   logic            cnt_load, cnt_dec, cnt_last;
   logic [CntW-1:0] cnt_val, cnt_unused;

   logic [63:0]        mul_s, mul_u;
   logic               div0;
   logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
   logic [31:0]        dvs_u, quo_u, rem_u;
   logic [31:0]        calc_hi, calc_lo;
   logic [CntW-1:0]    calc_n;

   // 33-bit signed division keeps 0x8000_0000 / -1 from overflowing.
   always_comb begin
      mul_s = $signed({{32{rs_val_E[31]}}, rs_val_E}) * $signed({{32{rt_val_E[31]}}, rt_val_E});
      mul_u = {32'd0, rs_val_E} * {32'd0, rt_val_E};
      div0  = (rt_val_E == 32'd0);
      dvd_s = $signed({rs_val_E[31], rs_val_E});
      dvs_s = div0 ? 33'sd1 : $signed({rt_val_E[31], rt_val_E});
      dvs_u = div0 ? 32'd1 : rt_val_E;
      quo_s = dvd_s / dvs_s;
      rem_s = dvd_s % dvs_s;
      quo_u = rs_val_E / dvs_u;
      rem_u = rs_val_E % dvs_u;

      calc_hi = mul_s[63:32];
      calc_lo = mul_s[31:0];
      calc_n  = CntW'(MULT_CYCLES);
      case (op_E)
         MDU_MULTU: begin
            calc_hi = mul_u[63:32];
            calc_lo = mul_u[31:0];
         end
         MDU_DIV, MDU_DIVU: begin
            calc_n = CntW'(DIV_CYCLES);
            if (div0) begin
`ifdef MDU_DIV0_HOLD_EN
               calc_hi = hi_q;
               calc_lo = lo_q;
               calc_n  = CntW'(1);
`else
               calc_hi = rs_val_E;
               calc_lo = 32'hFFFF_FFFF;
`endif
            end else if (op_E == MDU_DIV) begin
               calc_hi = rem_s[31:0];
               calc_lo = quo_s[31:0];
            end else begin
               calc_hi = rem_u;
               calc_lo = quo_u;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      done_d    = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = calc_n;
      case (state_q)
         MDU_IDLE: begin
            if (start_E) begin
               if (is_mdu_calc(op_E)) begin
                  pend_hi_d = calc_hi;
                  pend_lo_d = calc_lo;
                  cnt_load  = 1'b1;
                  state_d   = MDU_BUSY;
               end else if (op_E == MDU_MTHI) begin
                  hi_d = rs_val_E;
               end else if (op_E == MDU_MTLO) begin
                  lo_d = rs_val_E;
               end
            end
         end
         MDU_BUSY: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               done_d  = 1'b1;
               state_d = MDU_IDLE;
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MDU_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         done_q    <= done_d;
      end
   end

   mdu_latency_counter #(
      .CntW (CntW)
   ) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .cnt_o      (cnt_unused),
      .last_o     (cnt_last)
   );

   assign busy_o  = (state_q == MDU_BUSY);
   assign stall_o = md_D & (busy_o | (start_E & is_mdu_calc(op_E)));
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against a transaction-level arithmetic model.
module tb_mdu_ctrl;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_E;
   logic [2:0]  op_E;
   logic [31:0] rs_val_E, rt_val_E;
   logic        md_D;
   logic        busy_o, stall_o, done_o;
   logic [31:0] hi_o, lo_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   always #5 clk = ~clk;

   mdu_ctrl #(
      .MULT_CYCLES (MultN),
      .DIV_CYCLES  (DivN)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start_E  (start_E),
      .op_E     (op_E),
      .rs_val_E (rs_val_E),
      .rt_val_E (rt_val_E),
      .md_D     (md_D),
      .busy_o   (busy_o),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Architectural result of one calc op, from the ISA arithmetic rules.
   task automatic model_calc(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             output logic [31:0] ehi, output logic [31:0] elo,
                             output int unsigned lat);
      longint a, b, q, r;
      logic [63:0] p;
      ehi = m_hi;
      elo = m_lo;
      lat = (op < 3'd2) ? MultN : DivN;
      if (op == 3'd0) begin
         p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
         {ehi, elo} = p;
      end else if (op == 3'd1) begin
         p = {32'd0, rs} * {32'd0, rt};
         {ehi, elo} = p;
      end else if (rt == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
         lat = 1;
`else
         ehi = rs;
         elo = 32'hFFFF_FFFF;
`endif
      end else begin
         if (op == 3'd2) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
         end else begin
            a = longint'({32'd0, rs});
            b = longint'({32'd0, rt});
         end
         q = a / b;
         r = a - q * b;
         elo = q[31:0];
         ehi = r[31:0];
      end
   endtask

   task automatic run_calc(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic md, input logic inject);
      logic [31:0] ehi, elo;
      int unsigned lat, nb;
      model_calc(op, rs, rt, ehi, elo, lat);
      @(negedge clk);
      start_E = 1'b1; op_E = op; rs_val_E = rs; rt_val_E = rt; md_D = md;
      #1 check_eq("stall_issue", 64'(stall_o), 64'(md));
      @(posedge clk); #1;
      start_E = 1'b0;
      nb = 0;
      while (busy_o && nb < 100) begin
         nb++;
         check_eq("stall_busy", 64'(stall_o), 64'(md));
         check_eq("done_early", 64'(done_o), 64'd0);
         @(negedge clk);
         if (inject && nb == 2) begin
            start_E = 1'b1; op_E = 3'd0;
            rs_val_E = $urandom; rt_val_E = $urandom;
         end else begin
            start_E = 1'b0;
         end
         @(posedge clk); #1;
      end
      start_E = 1'b0;
      #0;
      check_eq("busy_len", 64'(nb), 64'(lat));
      check_eq("hilo", {hi_o, lo_o}, {ehi, elo});
      check_eq("done_pulse", 64'(done_o), 64'd1);
      #1 check_eq("stall_drop", 64'(stall_o), 64'd0);
      m_hi = ehi;
      m_lo = elo;
      @(posedge clk); #1;
      check_eq("done_once", 64'(done_o), 64'd0);
   endtask

   task automatic run_simple(input logic [2:0] op, input logic [31:0] rs);
      @(negedge clk);
      start_E = 1'b1; op_E = op; rs_val_E = rs; rt_val_E = $urandom; md_D = 1'b0;
      @(posedge clk); #1;
      start_E = 1'b0;
      if (op == 3'd4) m_hi = rs;
      if (op == 3'd5) m_lo = rs;
      check_eq("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
      check_eq("mt_busy", 64'(busy_o), 64'd0);
      check_eq("mt_done", 64'(done_o), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      reset_n = 1'b0; start_E = 1'b0; op_E = 3'd0;
      rs_val_E = 32'd0; rt_val_E = 32'd0; md_D = 1'b1;
      #12;
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_done", 64'(done_o), 64'd0);
      check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
      check_eq("rst_stall", 64'(stall_o), 64'd0);
      @(negedge clk);
      reset_n = 1'b1; md_D = 1'b0;

      run_calc(3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
      check_eq("t1_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_calc(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      check_eq("t2_const", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
      run_calc(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
      check_eq("t3_const", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
      run_simple(3'd4, 32'h1234);
      check_eq("t4_hi", 64'(hi_o), 64'h1234);
      run_calc(3'd2, 32'd100, 32'd7, 1'b0, 1'b1);
      run_simple(3'd6, 32'hDEAD);
      run_simple(3'd7, 32'hBEEF);

      // Abort a DIV in its 4th busy cycle.
      @(negedge clk);
      start_E = 1'b1; op_E = 3'd2; rs_val_E = 32'd50; rt_val_E = 32'd3;
      @(posedge clk); #1;
      start_E = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("abort_busy", 64'(busy_o), 64'd0);
      check_eq("abort_hilo", {hi_o, lo_o}, 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (DivN) begin
         @(posedge clk); #1;
         check_eq("abort_nodone", 64'(done_o), 64'd0);
      end

      run_simple(3'd5, 32'h5555_AAAA);
      run_calc(3'd3, 32'd9, 32'd0, 1'b1, 1'b0);
`ifndef MDU_DIV0_HOLD_EN
      check_eq("t6_const", {hi_o, lo_o}, 64'h0000_0009_FFFF_FFFF);
`endif
      run_calc(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (op < 3'd4) begin
            run_calc(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
         end else begin
            run_simple(op, $urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
